ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard on the shared open-drain ps2_clk/ps2_data lines. It complements `ps2_scanner`, which receives device-to-host traffic. It sits at the top level beside `ps2_scanner` and drives the lines through tristate buffers. While `tx_busy` is high, the scanner's `rx_done` is ignored.

---
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device-generated clock falls and checks the ack.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES       = 7500,
   parameter int START_TIMEOUT_CYCLES = 1_125_000,
   parameter int XFER_TIMEOUT_CYCLES  = 150_000,
   parameter int FILTER_LEN           = 8
) (
   input  logic       clk_75mhz,
   input  logic       rst_sync,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout
);

   localparam int MAX_TO = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
   localparam int TW = $clog2(MAX_TO + 1);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] REQ_LAST   = TW'(7);
   localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] CNT_ONE    = TW'(1);
   localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_RELEASE
   } state_t;

   logic [1:0]    clk_sync, data_sync;
   logic          clk_s, data_s;
   logic          clk_filt, fall;
   logic [FW-1:0] fcnt;

   state_t        state, state_d;
   logic [TW-1:0] cnt, cnt_d;
   logic [3:0]    bit_n, bit_d;
   logic [9:0]    frame, frame_d;
   logic          clk_oe_d, data_oe_d, busy_d, done_d, ack_err_d, timeout_d;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // Idle bus level is high, so synchronizers and filter reset to 1.
   always_ff @(posedge clk_75mhz or posedge rst_sync) begin
      if (rst_sync) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_filt  <= 1'b1;
         fcnt      <= '0;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         fall      <= clk_filt & ~clk_s & (fcnt == FILT_LAST);
         if (clk_s == clk_filt) begin
            fcnt <= '0;
         end else if (fcnt == FILT_LAST) begin
            clk_filt <= clk_s;
            fcnt     <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk_75mhz or posedge rst_sync) begin
      if (rst_sync) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_n       <= '0;
         frame       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_ack_err  <= 1'b0;
         tx_timeout  <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         bit_n       <= bit_d;
         frame       <= frame_d;
         ps2_clk_oe  <= clk_oe_d;
         ps2_data_oe <= data_oe_d;
         tx_busy     <= busy_d;
         tx_done     <= done_d;
         tx_ack_err  <= ack_err_d;
         tx_timeout  <= timeout_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
      state_d   = state;
      cnt_d     = cnt;
      bit_d     = bit_n;
      frame_d   = frame;
      clk_oe_d  = ps2_clk_oe;
      data_oe_d = ps2_data_oe;
      busy_d    = tx_busy;
      done_d    = 1'b0;
      ack_err_d = tx_ack_err;
      timeout_d = tx_timeout;

      case (state)
         S_IDLE: begin
            if (tx_start) begin
               frame_d   = {1'b1, ~^tx_data, tx_data};
               ack_err_d = 1'b0;
               timeout_d = 1'b0;
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            cnt_d = cnt + CNT_ONE;
            if (cnt == INH_LAST) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = cnt + CNT_ONE;
            if (cnt == REQ_LAST) begin
               cnt_d    = '0;
               bit_d    = '0;
               clk_oe_d = 1'b0;
               state_d  = S_XFER;
            end
         end
         S_XFER: begin
            cnt_d = cnt + CNT_ONE;
            if (fall) begin
               // Frame index 0..7 data, 8 parity, 9 stop; the timer restarts on fall 1.
               data_oe_d = ~frame[bit_n];
               bit_d     = bit_n + 4'd1;
               if (bit_n == 4'd0) cnt_d = '0;
               if (bit_n == 4'd9) state_d = S_ACK;
            end else if ((bit_n == 4'd0) ? (cnt == START_LAST) : (cnt == XFER_LAST)) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_ACK: begin
            cnt_d = cnt + CNT_ONE;
            if (fall) begin
               ack_err_d = data_s;
               state_d   = S_RELEASE;
            end else if (cnt == XFER_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_RELEASE: begin
            if (clk_filt && data_s) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
